reg_writeback: RTL and testbench
================================

# reg_writeback

Write-back queue that sits between the execute stage and the 4 x 8-bit `Registers` file, driving its `write`/`write_reg`/`write_data` port. Results arrive on a valid/ready stream, are buffered in a small in-order FIFO, and are drained into the register file one per clock. Lookup ports expose still-pending data so readers never see stale register contents while a write is queued.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `DATA_WIDTH`, 8, register data width.
- `ADDR_WIDTH`, 2, register index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset, sampled on `clk` rising edge).
- `in_valid`  in  1  a result is offered.
- `in_ready`  out  1  the queue can accept a result.
- `in_reg`  in  ADDR_WIDTH  destination register.
- `in_data`  in  DATA_WIDTH  result value.
- `hold`  in  1  freezes draining; enqueue still allowed.
- `write`  out  1  to `Registers.write`.
- `write_reg`  out  ADDR_WIDTH  to `Registers.write_reg`.
- `write_data`  out  DATA_WIDTH  to `Registers.write_data`.
- `fwd_reg1`, `fwd_reg2`  in  ADDR_WIDTH  registers being read.
- `fwd_hit1`, `fwd_hit2`  out  1  a pending entry targets that register.
- `fwd_data1`, `fwd_data2`  out  DATA_WIDTH  youngest pending value for that register.
- `pending`  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: circular FIFO of {reg, data}; read pointer, write pointer, and occupancy count.
- Push: occurs when `in_valid && in_ready`. `in_ready = (pending != DEPTH)`. No bypass when full, even if a pop happens in the same cycle.
- Drain: `write = (pending != 0) && !hold`. `write_reg`/`write_data` are driven combinationally from the head entry. The head is popped on each edge where `write` is 1; `Registers` samples on that same edge.
- Simultaneous push and pop: count is unchanged and both pointers advance. With one entry present, the new entry becomes the head after the edge.
- Pointers wrap modulo DEPTH.
- Forwarding: `fwd_hitN` = any occupied entry with reg == `fwd_regN`. `fwd_dataN` = data of the youngest such entry. When there is no hit, it is 0.
- The entry being written this cycle still counts as a hit, because the register file updates only at the edge.
- Order: the register file sees writes in acceptance order. For the same register, the last write wins.

## Timing
- Reset (`reset`=0 at an edge): pointers and count go to 0; all entries are discarded, including ones mid-drain. After that edge: `write`=0, `write_reg`=0, `write_data`=0, `in_ready`=1, `pending`=0, `fwd_hit*`=0, `fwd_data*`=0. Pushes offered during the reset cycle are dropped.
- Latency, empty queue:
  - Result accepted at edge N.
  - `write`=1 during cycle N..N+1.
  - Register file updated at edge N+1.
  - Readable from `Registers` after N+1.
- Throughput: one write per cycle while `hold`=0.
- Full: `in_ready`=0 until the edge after a pop.
- Empty with `in_valid`: no write in the same cycle.
- `hold`=1 keeps `write`=0 and the head unchanged. Forwarding stays valid while held.

## Configuration
- Macro `REG_WRITEBACK_COALESCE_EN`.
- Defined: a push whose `in_reg` matches the tail (youngest) entry overwrites that entry's data instead of allocating. Exception: if the tail is also the head being popped this cycle, the push allocates normally.
  - A coalesced push leaves `pending` unchanged.
  - `in_ready` is 1 when full if `in_valid && in_reg` matches a tail that is not being popped.
- Undefined: every accepted push allocates a new entry; the full rule is exactly `pending != DEPTH`.

## Test plan
- Reset then single write: push reg 2 / 0x55 → `write`=1, `write_reg`=2, `write_data`=0x55 for exactly one cycle. `Registers.read_data1` with `read_reg1`=2 reads 0x55 afterward.
- Fill with `hold`=1: push 0x11, 0x22, 0x33, 0x44 to regs 0–3 → `pending`=4, `in_ready`=0, a 5th push is refused. Release `hold` → four consecutive writes in order, then `write`=0.
- Forwarding: push reg 1/0xAA then reg 1/0xCC while held → `fwd_reg1`=1 gives hit=1, data=0xCC. `fwd_reg2`=3 gives hit=0, data=0. Drain → hits clear after the second write.
- Simultaneous push and pop with `pending`=1 → `pending` stays 1 and the next write carries the new data.
- Reset mid-drain with 3 entries pending → `pending`=0 and `write`=0 after the reset edge. No further writes occur and the register file keeps its prior contents.
- With `REG_WRITEBACK_COALESCE_EN`, held: push reg 3/0x01 then reg 3/0x02 → `pending`=1 and one write of 0x02. Without the macro: `pending`=2, then writes 0x01 followed by 0x02.

Source files
------------

// File: rtl/reg_writeback.sv
// In-order write-back queue feeding the register file write port, with lookup of still-pending results.
// Optional build macro REG_WRITEBACK_COALESCE_EN merges a push into a matching tail entry.
module reg_writeback #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_WIDTH-1:0]  in_reg,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   hold,
    output logic                   write,
    output logic [ADDR_WIDTH-1:0]  write_reg,
    output logic [DATA_WIDTH-1:0]  write_data,
    input  logic [ADDR_WIDTH-1:0]  fwd_reg1,
    input  logic [ADDR_WIDTH-1:0]  fwd_reg2,
    output logic                   fwd_hit1,
    output logic                   fwd_hit2,
    output logic [DATA_WIDTH-1:0]  fwd_data1,
    output logic [DATA_WIDTH-1:0]  fwd_data2,
    output logic [$clog2(DEPTH):0] pending
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] mem_reg_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_reg_d  [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  full, do_pop, do_push, alloc, coalesce;
    logic [PTR_W-1:0]      idx;
`ifdef REG_WRITEBACK_COALESCE_EN
    logic [PTR_W-1:0]      tail_ptr;
`endif

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = (count_q != '0) && !hold;
`ifdef REG_WRITEBACK_COALESCE_EN
        tail_ptr = wr_ptr_q - PTR_W'(1);
        // A lone entry leaving this cycle cannot absorb the push; it must allocate behind it.
        coalesce = in_valid && (count_q != '0) && (mem_reg_q[tail_ptr] == in_reg)
                   && !(do_pop && (count_q == CNT_W'(1)));
`else
        coalesce = 1'b0;
`endif
        in_ready = !full || coalesce;
        do_push  = in_valid && in_ready;
        alloc    = do_push && !coalesce;

        mem_reg_d  = mem_reg_q;
        mem_data_d = mem_data_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (alloc) begin
            mem_reg_d[wr_ptr_q]  = in_reg;
            mem_data_d[wr_ptr_q] = in_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
`ifdef REG_WRITEBACK_COALESCE_EN
        if (do_push && coalesce) begin
            mem_data_d[tail_ptr] = in_data;
        end
`endif
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({alloc, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        write      = do_pop;
        write_reg  = (count_q != '0) ? mem_reg_q[rd_ptr_q]  : '0;
        write_data = (count_q != '0) ? mem_data_q[rd_ptr_q] : '0;
        pending    = count_q;
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx       = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (mem_reg_q[idx] == fwd_reg1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = mem_data_q[idx];
                end
                if (mem_reg_q[idx] == fwd_reg2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = mem_data_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is qualified by the occupancy count, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_reg_q  <= mem_reg_d;
        mem_data_q <= mem_data_d;
    end
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback; a behavioural register file captures the write port.
module tb_reg_writeback;
    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, hold, write;
    logic [1:0] in_reg, write_reg, fwd_reg1, fwd_reg2;
    logic [7:0] in_data, write_data, fwd_data1, fwd_data2;
    logic       fwd_hit1, fwd_hit2;
    logic [2:0] pending;
    logic [7:0] rf [4];
    logic [7:0] snap [4];
    int total = 0;
    int bad   = 0;

    reg_writeback #(.DEPTH(4), .DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data), .hold(hold), .write(write),
        .write_reg(write_reg), .write_data(write_data), .fwd_reg1(fwd_reg1),
        .fwd_reg2(fwd_reg2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .pending(pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (write) rf[write_reg] <= write_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] r, input logic [7:0] d);
        in_valid = 1'b1; in_reg = r; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; hold = 1'b0; in_valid = 1'b1; in_reg = 2'd1; in_data = 8'h77;
        fwd_reg1 = 2'd1; fwd_reg2 = 2'd1;
        tick(); tick();
        #1;
        total++; if (write !== 1'b0) begin bad++; $display("FAIL rst_write got=%0h exp=0", write); end
        total++; if (write_reg !== 2'd0) begin bad++; $display("FAIL rst_write_reg got=%0h exp=0", write_reg); end
        total++; if (write_data !== 8'h00) begin bad++; $display("FAIL rst_write_data got=%0h exp=0", write_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL rst_pending got=%0d exp=0", pending); end
        total++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin bad++; $display("FAIL rst_fwd_hit got=%0h%0h exp=00", fwd_hit1, fwd_hit2); end
        total++; if (fwd_data1 !== 8'h00) begin bad++; $display("FAIL rst_fwd_data got=%0h exp=0", fwd_data1); end
        in_valid = 1'b0; reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        push(2'd2, 8'h55);
        #1;
        total++; if (write !== 1'b1) begin bad++; $display("FAIL single_write got=%0h exp=1", write); end
        total++; if (write_reg !== 2'd2) begin bad++; $display("FAIL single_reg got=%0h exp=2", write_reg); end
        total++; if (write_data !== 8'h55) begin bad++; $display("FAIL single_data got=%0h exp=55", write_data); end
        tick();
        total++; if (write !== 1'b0) begin bad++; $display("FAIL single_one_cycle got=%0h exp=0", write); end
        total++; if (rf[2] !== 8'h55) begin bad++; $display("FAIL single_rf got=%0h exp=55", rf[2]); end
    endtask

    task automatic test_fill_hold();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
        hold = 1'b1;
        for (int k = 0; k < 4; k++) push(2'(k), exp_d[k]);
        in_valid = 1'b1; in_reg = 2'd0; in_data = 8'h99;
        #1;
        total++; if (pending !== 3'd4) begin bad++; $display("FAIL fill_pending got=%0d exp=4", pending); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0h exp=0", in_ready); end
        total++; if (write !== 1'b0) begin bad++; $display("FAIL fill_hold_write got=%0h exp=0", write); end
        tick();
        in_valid = 1'b0;
        total++; if (pending !== 3'd4) begin bad++; $display("FAIL fill_refused got=%0d exp=4", pending); end
        hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (write !== 1'b1 || write_reg !== 2'(k) || write_data !== exp_d[k]) begin
                bad++; $display("FAIL fill_drain%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, write, write_reg, write_data, k, exp_d[k]);
            end
            tick();
        end
        total++; if (write !== 1'b0) begin bad++; $display("FAIL fill_end_write got=%0h exp=0", write); end
        total++; if (rf[0] !== 8'h11 || rf[1] !== 8'h22 || rf[2] !== 8'h33 || rf[3] !== 8'h44) begin
            bad++; $display("FAIL fill_rf got=%0h %0h %0h %0h exp=11 22 33 44", rf[0], rf[1], rf[2], rf[3]);
        end
    endtask

    task automatic test_forward();
        hold = 1'b1; fwd_reg1 = 2'd1; fwd_reg2 = 2'd3;
        push(2'd1, 8'hAA);
        push(2'd1, 8'hCC);
        #1;
        total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 8'hCC) begin bad++; $display("FAIL fwd_hit1 got=%0h/%0h exp=1/cc", fwd_hit1, fwd_data1); end
        total++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 8'h00) begin bad++; $display("FAIL fwd_miss2 got=%0h/%0h exp=0/0", fwd_hit2, fwd_data2); end
        hold = 1'b0;
`ifndef REG_WRITEBACK_COALESCE_EN
        #1;
        total++; if (write_data !== 8'hAA || fwd_hit1 !== 1'b1 || fwd_data1 !== 8'hCC) begin
            bad++; $display("FAIL fwd_drain1 got=%0h/%0h/%0h exp=aa/1/cc", write_data, fwd_hit1, fwd_data1);
        end
        tick();
`endif
        #1;
        total++; if (write_data !== 8'hCC || fwd_hit1 !== 1'b1) begin bad++; $display("FAIL fwd_drain2 got=%0h/%0h exp=cc/1", write_data, fwd_hit1); end
        tick();
        total++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 8'h00) begin bad++; $display("FAIL fwd_clear got=%0h/%0h exp=0/0", fwd_hit1, fwd_data1); end
    endtask

    task automatic test_simul();
        hold = 1'b1;
        push(2'd0, 8'h10);
        hold = 1'b0; in_valid = 1'b1; in_reg = 2'd2; in_data = 8'h20;
        #1;
        total++; if (write !== 1'b1 || write_data !== 8'h10 || in_ready !== 1'b1) begin
            bad++; $display("FAIL simul_pop got=%0h/%0h/%0h exp=1/10/1", write, write_data, in_ready);
        end
        tick();
        in_valid = 1'b0;
        total++; if (pending !== 3'd1) begin bad++; $display("FAIL simul_pending got=%0d exp=1", pending); end
        total++; if (write !== 1'b1 || write_reg !== 2'd2 || write_data !== 8'h20) begin
            bad++; $display("FAIL simul_next got=%0h/%0h/%0h exp=1/2/20", write, write_reg, write_data);
        end
        tick();
        total++; if (pending !== 3'd0 || rf[2] !== 8'h20) begin bad++; $display("FAIL simul_done got=%0d/%0h exp=0/20", pending, rf[2]); end
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        push(2'd0, 8'hA1);
        push(2'd1, 8'hB2);
        push(2'd3, 8'hC3);
        hold = 1'b0; reset = 1'b0;
        #1;
        total++; if (write !== 1'b1 || pending !== 3'd3) begin bad++; $display("FAIL rmid_pre got=%0h/%0d exp=1/3", write, pending); end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) snap[k] = rf[k];
        #1;
        total++; if (pending !== 3'd0 || write !== 1'b0) begin bad++; $display("FAIL rmid_post got=%0d/%0h exp=0/0", pending, write); end
        tick(); tick(); tick();
        total++; if (write !== 1'b0 || rf[1] !== snap[1] || rf[3] !== snap[3]) begin
            bad++; $display("FAIL rmid_rf got=%0h/%0h/%0h exp=0/%0h/%0h", write, rf[1], rf[3], snap[1], snap[3]);
        end
    endtask

    task automatic test_coalesce();
        hold = 1'b1;
        push(2'd3, 8'h01);
        push(2'd3, 8'h02);
        #1;
        hold = 1'b0;
`ifdef REG_WRITEBACK_COALESCE_EN
        total++; if (pending !== 3'd1) begin bad++; $display("FAIL coal_pending got=%0d exp=1", pending); end
        #1;
        total++; if (write !== 1'b1 || write_data !== 8'h02) begin bad++; $display("FAIL coal_write got=%0h/%0h exp=1/02", write, write_data); end
        tick();
`else
        total++; if (pending !== 3'd2) begin bad++; $display("FAIL coal_pending got=%0d exp=2", pending); end
        #1;
        total++; if (write !== 1'b1 || write_data !== 8'h01) begin bad++; $display("FAIL coal_write1 got=%0h/%0h exp=1/01", write, write_data); end
        tick();
        total++; if (write !== 1'b1 || write_data !== 8'h02) begin bad++; $display("FAIL coal_write2 got=%0h/%0h exp=1/02", write, write_data); end
        tick();
`endif
        total++; if (write !== 1'b0 || rf[3] !== 8'h02) begin bad++; $display("FAIL coal_end got=%0h/%0h exp=0/02", write, rf[3]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_hold();
        test_forward();
        test_simul();
        test_reset_mid();
        test_coalesce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
